// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: funct3 codes, FSM states,
// the latched request record and the request legality check.
package lsu_pkg;

  localparam int ADDR_W  = 8;
  localparam int WORD_AW = ADDR_W - 2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  typedef struct packed {
    logic              we;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } req_t;

  // Unsigned widths exist only for loads; halves and words must be naturally aligned.
  function automatic logic req_is_err(input logic we, input logic [2:0] funct3,
                                      input logic [1:0] lane);
    logic legal;
    case (funct3)
      F3_B:    legal = 1'b1;
      F3_H:    legal = !lane[0];
      F3_W:    legal = (lane == 2'b00);
      F3_BU:   legal = !we;
      F3_HU:   legal = !we && !lane[0];
      default: legal = 1'b0;
    endcase
    return !legal;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core request/response handshake plus the word-wide data-memory port.
// The slave modport is the load/store unit; master is the core/memory side.
interface lsu_if;
  import lsu_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [2:0]         req_funct3;
  logic [ADDR_W-1:0]  req_addr;
  logic [31:0]        req_wdata;
  logic               resp_valid;
  logic [31:0]        resp_rdata;
  logic               resp_err;
  logic               mem_read;
  logic               mem_write;
  logic [WORD_AW-1:0] mem_addr;
  logic [31:0]        mem_wdata;
  logic [31:0]        mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte/half lane steering: extracts and extends load data from a memory word,
// and merges sub-word store data into the old word for read-modify-write.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    byte_sel = word_i[8*lane_i +: 8];
    half_sel = word_i[16*lane_i[1] +: 16];
    load_o   = '0;
    store_o  = word_i;
    case (funct3_i)
      F3_B: begin
        load_o                   = {{24{byte_sel[7]}}, byte_sel};
        store_o[8*lane_i +: 8]   = wdata_i[7:0];
      end
      F3_H: begin
        load_o                     = {{16{half_sel[15]}}, half_sel};
        store_o[16*lane_i[1] +: 16] = wdata_i[15:0];
      end
      F3_W: begin
        load_o  = word_i;
        store_o = wdata_i;
      end
      F3_BU:   load_o = {24'b0, byte_sel};
      F3_HU:   load_o = {16'b0, half_sel};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts byte-addressed core requests and sequences
// word accesses (read, write or read-modify-write) to the 64x32 data memory.
module lsu_ctrl
  import lsu_pkg::*;
(
  input logic   clk,
  input logic   rst_n,
  lsu_if.slave  bus
);

  state_e             state_q, state_d;
  req_t               req_q, req_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [WORD_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_err_q, resp_err_d;
  logic [31:0]        resp_rdata_q, resp_rdata_d;
  logic [31:0]        load_data, merged_word;

  lsu_lane_align u_align (
    .word_i   (bus.mem_rdata),
    .wdata_i  (req_q.wdata),
    .lane_i   (req_q.addr[1:0]),
    .funct3_i (req_q.funct3),
    .load_o   (load_data),
    .store_o  (merged_word)
  );

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    unique case (state_q)
      IDLE: if (bus.req_valid) begin
        req_d      = '{we: bus.req_we, funct3: bus.req_funct3,
                       addr: bus.req_addr, wdata: bus.req_wdata};
        mem_addr_d = bus.req_addr[ADDR_W-1:2];
        if (req_is_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0])) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
        end else if (bus.req_we && bus.req_funct3 == F3_W) begin
          state_d     = WR;
          mem_write_d = 1'b1;
          mem_wdata_d = bus.req_wdata;
        end else begin
          // Loads and sub-word stores both need the current word first.
          state_d    = RD;
          mem_read_d = 1'b1;
        end
      end
      RD: if (req_q.we) begin
        state_d     = WR;
        mem_write_d = 1'b1;
        mem_wdata_d = merged_word;
      end else begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = load_data;
      end
      WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = '0;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_q        <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: a byte-array reference model predicts each response,
// a monitor compares responses, latency and memory-port activity as they appear.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_if bus ();
  lsu_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Data memory: combinational read, write on the edge after mem_write.
  logic [31:0] mem [64];
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (rst_n && bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          rds;
    int          wrs;
    int          acc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] ref_bytes [256];
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  bit         busy = 1'b0;
  int         rd_cnt = 0;
  int         wr_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: byte-addressed little-endian memory, responses from the ISA rules.
  function automatic exp_t model(input logic we, input logic [2:0] f3,
                                 input logic [7:0] a, input logic [31:0] wd);
    exp_t e;
    int   n;
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: n = 1;
      3'd1, 3'd5: n = 2;
      3'd2:       n = 4;
      default:    n = 0;
    endcase
    e.acc = 0;
    if (n == 0 || (we && f3[2]) || (int'(a) % n != 0)) begin
      e.err = 1'b1; e.rdata = '0; e.lat = 1; e.rds = 0; e.wrs = 0;
    end else if (we) begin
      for (int i = 0; i < n; i++) ref_bytes[int'(a) + i] = wd[8*i +: 8];
      e.err = 1'b0; e.rdata = '0; e.wrs = 1;
      e.lat = (n == 4) ? 2 : 3;
      e.rds = (n == 4) ? 0 : 1;
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[int'(a) + i]) << (8*i));
      if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      e.err = 1'b0; e.rdata = v; e.lat = 2; e.rds = 1; e.wrs = 0;
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [7:0] a,
                       input logic [31:0] wd);
    exp_t e;
    int   guard = 0;
    int   acc;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    while (!bus.req_ready) begin
      @(negedge clk);
      guard++;
      if (guard > 50) begin
        n_checks++; n_fail++;
        $display("FAIL accept_timeout: req_ready stuck at %b expected 1", bus.req_ready);
        bus.req_valid = 1'b0;
        return;
      end
    end
    acc = cyc;
    @(posedge clk);
    e = model(we, f3, a, wd);
    e.acc = acc;
    exp_q.push_back(e);
    busy = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int guard = 0;
    bus.req_valid = 1'b0;
    while (busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      n_checks++; n_fail++;
      $display("FAIL resp_timeout: busy=%b expected 0", busy);
      busy = 1'b0;
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: protocol checks every cycle, scoreboard pop on each response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_cnt = 0; wr_cnt = 0;
      end else begin
        check("rd_wr_exclusive", 32'(bus.mem_read & bus.mem_write), 32'd0);
        check("req_ready", 32'(bus.req_ready), 32'(!busy));
        if (bus.mem_read)  rd_cnt++;
        if (bus.mem_write) wr_cnt++;
        if (exp_q.size() == 0) begin
          check("spurious_resp", 32'(bus.resp_valid), 32'd0);
        end else if (bus.resp_valid) begin
          e = exp_q.pop_front();
          check("resp_err",   32'(bus.resp_err), 32'(e.err));
          check("resp_rdata", bus.resp_rdata, e.rdata);
          check("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
          check("mem_read_cycles", 32'(rd_cnt), 32'(e.rds));
          check("mem_write_cycles", 32'(wr_cnt), 32'(e.wrs));
          rd_cnt = 0; wr_cnt = 0;
          busy = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [31:0] w;
    logic [2:0]  f3;
    logic [7:0]  a;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      mem[i] = w;
      for (int b = 0; b < 4; b++) ref_bytes[4*i + b] = w[8*b +: 8];
    end
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0;

    #1;
    check("rst_req_ready",  32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_mem_read",   32'(bus.mem_read), 32'd0);
    check("rst_mem_write",  32'(bus.mem_write), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_mem_wdata",  bus.mem_wdata, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Word store/load round trip, then byte merge into the middle of the word.
    issue(1'b1, F3_W, 8'h10, 32'hDEAD_BEEF); wait_idle();
    check("sw_word4", mem[4], 32'hDEAD_BEEF);
    issue(1'b0, F3_W, 8'h10, 32'h0); wait_idle();
    issue(1'b1, F3_B, 8'h11, 32'h0000_00AA); wait_idle();
    check("sb_word4", mem[4], 32'hDEAD_AAEF);
    issue(1'b0, F3_B,  8'h11, 32'h0); wait_idle();
    issue(1'b0, F3_BU, 8'h11, 32'h0); wait_idle();
    issue(1'b0, F3_H,  8'h12, 32'h0); wait_idle();
    issue(1'b0, F3_HU, 8'h12, 32'h0); wait_idle();

    // Faults: misalignment and illegal funct3 leave memory untouched.
    issue(1'b0, F3_W, 8'h12, 32'h0); wait_idle();
    issue(1'b1, F3_H, 8'h13, 32'h1234_5678); wait_idle();
    issue(1'b0, 3'b011, 8'h10, 32'h0); wait_idle();
    issue(1'b1, F3_BU, 8'h10, 32'h0); wait_idle();
    check("fault_word4", mem[4], 32'hDEAD_AAEF);

    // Back-to-back with req_valid held high across the RESP cycle.
    issue(1'b1, F3_W, 8'h20, 32'h1234_5678);
    issue(1'b0, F3_W, 8'h20, 32'h0);
    wait_idle();

    // Randomized mix, clustered addresses so stores and loads overlap.
    for (int k = 0; k < 150; k++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(8'h40 + $urandom_range(0, 31));
      issue(1'($urandom), f3, a, $urandom);
      if ($urandom_range(0, 1) == 0) begin
        bus.req_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    wait_idle();

    // Reset while an SB sits in RD: aborted, no write, no response afterwards.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_B;
    bus.req_addr = 8'h31; bus.req_wdata = 32'h0000_0055;
    @(posedge clk);
    busy = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    w = mem[12];
    check("sb_in_rd", 32'(bus.mem_read), 32'd1);
    rst_n = 1'b0;
    busy = 1'b0;
    #1;
    check("abort_req_ready",  32'(bus.req_ready), 32'd1);
    check("abort_mem_read",   32'(bus.mem_read), 32'd0);
    check("abort_mem_write",  32'(bus.mem_write), 32'd0);
    check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("abort_mem_addr",   32'(bus.mem_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_word12", mem[12], w);

    for (int i = 0; i < 64; i++)
      check($sformatf("final_word%0d", i), mem[i],
            {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit: the initiator side of the data-memory port (MemRead/MemWrite/6-bit word addr/data_in/data_out).
- Accepts byte-addressed load/store requests from the core pipeline and issues word accesses to the 64x32 data memory.
- Memory writes whole words only, so SB/SH are done as a read-modify-write.
- Performs alignment checks and sign/zero extension of load data.

Parameters:
- ADDR_W, 8, byte-address width from the core (64 words x 4 bytes).
- WORD_AW, 6, word-address width to memory; equals ADDR_W-2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core request strobe.
- req_ready  out  1  unit can accept a request; equals (state==IDLE).
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; low byte/half used for SB/SH.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_err  out  1  misaligned address or illegal funct3, valid with resp_valid.
- mem_read  out  1  to memory MemRead.
- mem_write  out  1  to memory MemWrite; memory writes on the next posedge.
- mem_addr  out  WORD_AW  req_addr[ADDR_W-1:2] of the latched request.
- mem_wdata  out  32  to memory data_in.
- mem_rdata  in  32  from memory data_out; combinational, valid while mem_read=1.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All registered outputs 0: resp_valid, resp_rdata, resp_err, mem_read, mem_write, mem_addr, mem_wdata.
  - req_ready=1.
- Handshake:
  - Accept when req_valid && req_ready. Latch we, funct3, addr, wdata.
  - req_ready is 0 in every non-IDLE state. No new request is accepted until the RESP cycle has ended.
- Request check at accept:
  - err = illegal funct3 (011, 110, 111 for loads; any value other than 000/001/010 for stores), or
  - H/HU with addr[0]!=0, or
  - W with addr[1:0]!=0.
  - If err: go to RESP with resp_err=1. No mem_read/mem_write is asserted.
- FSM: IDLE, RD, WR, RESP.
  - Load: IDLE -> RD -> RESP.
    - In RD: mem_read=1 and the word is captured at the clock edge.
    - resp_valid in the 3rd cycle after accept (accept = cycle 0, RESP = cycle 2).
  - SW: IDLE -> WR -> RESP. In WR: mem_write=1 and mem_wdata=wdata.
  - SB/SH: IDLE -> RD -> WR -> RESP.
    - RD captures the old word.
    - WR drives the merged word: the selected byte lane (addr[1:0]) or half lane (addr[1]) is replaced and the other lanes keep the old value.
    - resp_valid in cycle 3.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE. A request presented in that cycle is not accepted, because req_ready=0.
- Load extract:
  - Lane select by addr[1:0].
  - B/H sign-extend from bit 7/15. BU/HU zero-extend. W is passed through.
- mem_read and mem_write are never asserted together. mem_addr stays stable from RD through WR.
- resp_rdata holds its value until the next RESP, except that a store or fault RESP drives 0.
- Reset during RD/WR aborts the operation. A write is guaranteed not to occur only if rst_n falls before the WR-cycle clock edge. No resp_valid is produced after reset.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum {IDLE, RD, WR, RESP}.
- One natural sub-module, lsu_lane_align (combinational), containing:
  - load extract/extend: word, addr[1:0], funct3 -> rdata.
  - store merge: old word, wdata, addr[1:0], funct3 -> new word.
- The FSM stays in lsu_ctrl.

Test Plan:
- SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10 -> mem word 4 = 0xDEADBEEF; load resp_rdata=0xDEADBEEF at cycle 2; SW resp at cycle 2 with resp_rdata=0.
- Word 4=0xDEADBEEF, then SB addr=0x11 wdata=0x000000AA -> RD, WR, resp at cycle 3; word 4=0xDEADAAEF; mem_write high exactly 1 cycle.
- Word 4=0xDEADAAEF: LB 0x11 -> 0xFFFFFFAA; LBU 0x11 -> 0x000000AA; LH 0x12 -> 0xFFFFDEAD; LHU 0x12 -> 0x0000DEAD.
- LW addr=0x12 and SH addr=0x13 -> resp_err=1 at cycle 1; mem_read and mem_write stay 0; memory unchanged. Load funct3=011 -> resp_err=1.
- Back-to-back req_valid held high for SW 0x20=0x12345678 then LW 0x20 -> second request accepted only after RESP; load returns 0x12345678; req_ready=0 through RD/WR/RESP.
- Assert rst_n=0 mid-SB during RD -> outputs 0 immediately; state IDLE; target word unchanged; no resp_valid after reset release.
